// File: rtl/seq_alu_unit.sv
// seq_alu_unit: multi-cycle signed ALU (add, sub, rem, mul) with valid/ready on both sides.
// Optional build macro ALU_MUL_EARLY_TERM_EN lets mul stop once the remaining multiplier is zero.
module seq_alu_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               sign_flag,
    output logic               overflow,
    output logic               zero_flag,
    output logic               div_zero
);

    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_FINAL,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_REM = 2'b10,
        OP_MUL = 2'b11
    } op_t;

    state_t           state;
    state_t           next_state;
    op_t              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] rem_q;
    logic [RW-1:0]    mul_acc;
    logic [RW-1:0]    mul_cand;
    logic [CW-1:0]    iter_cnt;
    logic             neg_q;
    logic             b_zero_q;

    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   addsub_sum;
    logic [RW-1:0]    addsub_res;
    logic [RW-1:0]    mul_acc_nx;
    logic [WIDTH-1:0] mb_shift;
    logic [WIDTH:0]   rem_trial;
    logic             rem_fits;
    logic [WIDTH-1:0] rem_diff;
    logic [WIDTH-1:0] rem_r_nx;
    logic [RW-1:0]    rem_ext;
    logic [RW-1:0]    fin_res;
    logic             fin_ovf;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign sign_flag = result[RW-1];

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand maps cleanly.
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    assign a_ext      = {a_q[WIDTH-1], a_q};
    assign b_ext      = {b_q[WIDTH-1], b_q};
    assign addsub_sum = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    assign addsub_res = {{(WIDTH-1){addsub_sum[WIDTH]}}, addsub_sum};

    assign mul_acc_nx = mag_b_q[0] ? (mul_acc + mul_cand) : mul_acc;
    assign mb_shift   = mag_b_q >> 1;

    // Restoring step: remainder stays below |b|, so only the compare needs the extra bit.
    assign rem_trial = {rem_r, rem_q[WIDTH-1]};
    assign rem_fits  = (rem_trial >= {1'b0, mag_b_q});
    assign rem_diff  = rem_trial[WIDTH-1:0] - mag_b_q;
    assign rem_r_nx  = rem_fits ? rem_diff : rem_trial[WIDTH-1:0];
    assign rem_ext   = {{WIDTH{1'b0}}, rem_r};

`ifdef ALU_MUL_EARLY_TERM_EN
    assign last_iter = (iter_cnt == CW'(WIDTH - 1)) || ((op_q == OP_MUL) && (mb_shift == '0));
`else
    assign last_iter = (iter_cnt == CW'(WIDTH - 1));
`endif

    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_ADD, OP_SUB: fin_res = addsub_res;
            OP_REM: begin
                if (b_zero_q)
                    fin_res = {{WIDTH{a_q[WIDTH-1]}}, a_q};
                else
                    fin_res = neg_q ? -rem_ext : rem_ext;
            end
            OP_MUL:  fin_res = neg_q ? -mul_acc : mul_acc;
            default: fin_res = '0;
        endcase
        fin_ovf = (op_q != OP_REM) &&
                  !((&fin_res[RW-1:WIDTH-1]) || (~|fin_res[RW-1:WIDTH-1]));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // add/sub skip the iteration phase and go straight to the finalise edge.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (in_valid) next_state = op[1] ? S_EXEC : S_FINAL;
            S_EXEC:  if (last_iter) next_state = S_FINAL;
            S_FINAL: next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            mag_b_q   <= '0;
            rem_r     <= '0;
            rem_q     <= '0;
            mul_acc   <= '0;
            mul_cand  <= '0;
            iter_cnt  <= '0;
            neg_q     <= 1'b0;
            b_zero_q  <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            zero_flag <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= op_t'(op);
                        a_q      <= a;
                        b_q      <= b;
                        mag_b_q  <= abs_b;
                        rem_r    <= '0;
                        rem_q    <= abs_a;
                        mul_acc  <= '0;
                        mul_cand <= {{WIDTH{1'b0}}, abs_a};
                        iter_cnt <= '0;
                        b_zero_q <= (b == '0);
                        neg_q    <= op[0] ? (a[WIDTH-1] ^ b[WIDTH-1]) : a[WIDTH-1];
                    end
                end
                S_EXEC: begin
                    iter_cnt <= iter_cnt + CW'(1);
                    if (op_q == OP_MUL) begin
                        mul_acc  <= mul_acc_nx;
                        mul_cand <= mul_cand << 1;
                        mag_b_q  <= mb_shift;
                    end else if (!b_zero_q) begin
                        rem_r <= rem_r_nx;
                        rem_q <= {rem_q[WIDTH-2:0], rem_fits};
                    end
                end
                S_FINAL: begin
                    result    <= fin_res;
                    overflow  <= fin_ovf;
                    zero_flag <= (fin_res == '0);
                    div_zero  <= (op_q == OP_REM) && b_zero_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: scoreboard bench for seq_alu_unit (WIDTH=8), directed cases plus random ops.
module tb_seq_alu_unit;

    localparam int W  = 8;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    op = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] result;
    logic          sign_flag;
    logic          overflow;
    logic          zero_flag;
    logic          div_zero;

    typedef struct {
        logic [RW-1:0] res;
        logic          sgn;
        logic          ovf;
        logic          zro;
        logic          dz;
        int            lat;
    } exp_t;

    exp_t sb_q[$];
    int   num_checks = 0;
    int   num_fail = 0;

    seq_alu_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sign_flag (sign_flag),
        .overflow  (overflow),
        .zero_flag (zero_flag),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model works on plain integers, independent of the bit-level datapath.
    function automatic exp_t modelOp(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] opv);
        exp_t   e;
        longint sa, sb, r, mag;
        int     msb;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (opv)
            2'b00:   r = sa + sb;
            2'b01:   r = sa - sb;
            2'b10:   r = (sb == 0) ? sa : (sa % sb);
            default: r = sa * sb;
        endcase
        e.res = r[RW-1:0];
        e.sgn = (r < 0);
        e.zro = (r == 0);
        e.dz  = (opv == 2'b10) && (sb == 0);
        e.ovf = (opv != 2'b10) && ((r < -(2 ** (W - 1))) || (r > (2 ** (W - 1)) - 1));
        e.lat = opv[1] ? (W + 1) : 1;
        mag = (sb < 0) ? -sb : sb;
        msb = 0;
        for (int i = 0; i < W; i++)
            if (mag[i]) msb = i;
`ifdef ALU_MUL_EARLY_TERM_EN
        if (opv == 2'b11) e.lat = msb + 2;
`endif
        return e;
    endfunction

    task automatic checkResult(input exp_t e);
        checkOutput("result", result, e.res);
        checkOutput("sign_flag", sign_flag, e.sgn);
        checkOutput("overflow", overflow, e.ovf);
        checkOutput("zero_flag", zero_flag, e.zro);
        checkOutput("div_zero", div_zero, e.dz);
    endtask

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [1:0] opv, input int stall);
        exp_t e;
        int   lat;
        @(negedge clk);
        checkOutput("in_ready_idle", in_ready, 1);
        a = av;
        b = bv;
        op = opv;
        in_valid = 1'b1;
        out_ready = 1'b0;
        sb_q.push_back(modelOp(av, bv, opv));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        op = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("sb_depth", sb_q.size(), 1);
        e = sb_q.pop_front();
        checkOutput("latency", lat, e.lat);
        checkResult(e);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = W'($urandom);
            b = W'($urandom);
            op = 2'($urandom);
            @(posedge clk);
            #1;
            checkOutput("stall_out_valid", out_valid, 1);
            checkOutput("stall_in_ready", in_ready, 0);
            checkResult(e);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("post_out_valid", out_valid, 0);
        checkOutput("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_flags", {overflow, zero_flag, div_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'd100, 8'd27, 2'b00, 0);
        applyStimulus(8'd100, 8'd28, 2'b00, 1);
        applyStimulus(8'd3, 8'd3, 2'b01, 0);
        applyStimulus(8'h80, 8'h7F, 2'b01, 0);
        applyStimulus(8'h80, 8'h80, 2'b11, 0);
        applyStimulus(8'd3, 8'hFF, 2'b11, 0);
        applyStimulus(8'd3, 8'd1, 2'b11, 0);
        applyStimulus(8'h7F, 8'd0, 2'b11, 0);
        applyStimulus(8'hF9, 8'd2, 2'b10, 0);
        applyStimulus(8'd5, 8'd0, 2'b10, 0);
        applyStimulus(8'h80, 8'hFF, 2'b10, 0);
        applyStimulus(8'd100, 8'hF9, 2'b10, 0);
        for (int i = 0; i < 24; i++)
            applyStimulus(W'($urandom), W'($urandom), 2'($urandom), $urandom_range(0, 2));
        applyStimulus(8'h80, 8'h80, 2'b11, 10);

        // Abort a mul in its fourth iteration; state and outputs must be wiped.
        @(negedge clk);
        a = 8'd3;
        b = 8'h85;
        op = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_flags", {overflow, zero_flag, div_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'd20, 8'd22, 2'b00, 0);
        applyStimulus(8'd3, 8'd1, 2'b11, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
